// File: rtl/accum_pkg.sv
// Shared types and default sizing for the accumulator lane array.
package accum_pkg;

  typedef enum logic [1:0] {
    XOR_AND = 2'd0,
    XOR_OR  = 2'd1,
    LOAD    = 2'd2,
    HOLD    = 2'd3
  } accum_mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned LANES_DEF = 2;
  localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/accum_lane.sv
// One accumulator lane: data register q, independent parity shadow p,
// mode-selected update and a combinational q/p parity mismatch flag.
// Ports: clk_i/rst_i (async, active-high), clear_i (sync clear),
//        accept_i (beat accepted), mode_i, a_i/b_i operands,
//        q_new_o (post-update value), mismatch_o (^q != p).
module accum_lane
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             accept_i,
  input  accum_mode_e      mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] q_new_o,
  output logic             mismatch_o
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             p;
  logic             p_new;
  logic             p_nxt;
  logic [WIDTH-1:0] ab_and;
  logic [WIDTH-1:0] ab_or;

  // p is derived from operand parity only, never from q, so a corrupted q
  // bit shows up as a parity disagreement.
  always_comb begin
    ab_and  = a_i & b_i;
    ab_or   = a_i | b_i;
    q_new_o = q;
    p_new   = p;
    case (mode_i)
      XOR_AND: begin
        q_new_o = q ^ ab_and;
        p_new   = p ^ (^ab_and);
      end
      XOR_OR: begin
        q_new_o = q ^ ab_or;
        p_new   = p ^ (^ab_or);
      end
      LOAD: begin
        q_new_o = ab_and;
        p_new   = ^ab_and;
      end
      default: begin
        q_new_o = q;
        p_new   = p;
      end
    endcase
    q_nxt = accept_i ? q_new_o : q;
    p_nxt = accept_i ? p_new : p;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q <= '0;
      p <= 1'b0;
    end else if (clear_i) begin
      q <= '0;
      p <= 1'b0;
    end else begin
      q <= q_nxt;
      p <= p_nxt;
    end
  end

  assign mismatch_o = (^q) != p;

endmodule

// File: rtl/accum_lane_array.sv
// LANES independent WIDTH-bit accumulators behind a single-entry
// valid/ready output buffer, with a saturating accepted-beat counter and a
// sticky parity-shadow error output.
// Ports: clk_i, rst_i (async, active-high), clear_i (sync clear),
//        in_valid_i/in_ready_o, mode_i, a_i/b_i (lane k at [k*WIDTH +: WIDTH]),
//        out_valid_o/out_ready_i, y_o (q_new | a per lane), beats_o, err_o.
module accum_lane_array
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [1:0]             mode_i,
  input  logic [LANES*WIDTH-1:0] a_i,
  input  logic [LANES*WIDTH-1:0] b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*WIDTH-1:0] y_o,
  output logic [CNT_W-1:0]       beats_o,
  output logic                   err_o
);

  out_state_e             state;
  out_state_e             state_nxt;
  logic                   accept;
  accum_mode_e            mode;
  logic [LANES*WIDTH-1:0] q_new;
  logic [LANES-1:0]       lane_mismatch;

  assign mode        = accum_mode_e'(mode_i);
  assign out_valid_o = (state == FULL);
  assign in_ready_o  = !clear_i && (!out_valid_o || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    accum_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (clear_i),
      .accept_i  (accept),
      .mode_i    (mode),
      .a_i       (a_i[k*WIDTH +: WIDTH]),
      .b_i       (b_i[k*WIDTH +: WIDTH]),
      .q_new_o   (q_new[k*WIDTH +: WIDTH]),
      .mismatch_o(lane_mismatch[k])
    );
  end

  always_comb begin
    state_nxt = state;
    if (clear_i) begin
      state_nxt = EMPTY;
    end else if (accept) begin
      state_nxt = FULL;
    end else if (out_ready_i) begin
      state_nxt = EMPTY;
    end
  end

  // Per-lane q_new | a is a plain bitwise OR over the packed bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= EMPTY;
      y_o     <= '0;
      beats_o <= '0;
      err_o   <= 1'b0;
    end else if (clear_i) begin
      state   <= EMPTY;
      y_o     <= '0;
      beats_o <= '0;
      err_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        y_o <= q_new | a_i;
      end
      if (accept && (beats_o != '1)) begin
        beats_o <= beats_o + CNT_W'(1);
      end
      if (|lane_mismatch) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accum_lane_array.sv
module tb_accum_lane_array;
  import accum_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  mode = 2'd0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] y;
  logic [7:0]  beats;
  logic        err;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_y;
  logic [3:0]  s_beats;
  logic        s_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  accum_lane_array #(.WIDTH(8), .LANES(2), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mode_i(mode), .a_i(a), .b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .y_o(y), .beats_o(beats), .err_o(err)
  );

  accum_lane_array #(.WIDTH(8), .LANES(2), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .clear_i(1'b0),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .mode_i(2'd0), .a_i(16'h0000), .b_i(16'h0000),
    .out_valid_o(s_out_valid), .out_ready_i(1'b1),
    .y_o(s_y), .beats_o(s_beats), .err_o(s_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one beat, push its hand-computed result when it is going to be accepted.
  task automatic send(input logic [1:0] m, input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] ey);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; mode = m; a = av; b = bv;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready && !clear) begin
        sb.push_back(ey);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles expected acceptance");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every output transfer is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL y_o_unexpected: got 0x%0h expected no output beat", y);
        end else begin
          chk("y_o", y, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_beats", beats, 0);
    chk("rst_err", err, 0);
    #20 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Basic XOR_AND beat.
    send(XOR_AND, 16'hFF0F, 16'h3CFF, 16'hFF0F);
    chk("b1_out_valid", out_valid, 1);
    chk("b1_beats", beats, 1);
    chk("b1_err", err, 0);

    // Backpressure: beat 1 held, beat 2 (HOLD) stalls.
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; mode = HOLD; a = 16'h1020; b = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_y", y, 16'hFF0F);
      chk("stall_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_in_ready", in_ready, 1);
    sb.push_back(16'h3C2F);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("b2_beats", beats, 2);

    // Modes: LOAD, HOLD, XOR_OR, then HOLD with a=0 exposes q.
    send(LOAD, 16'hAAAA, 16'hF0F0, 16'hAAAA);
    send(HOLD, 16'h0000, 16'hFFFF, 16'hA0A0);
    chk("hold_beats", beats, 4);
    send(XOR_OR, 16'h0101, 16'h0202, 16'hA3A3);
    send(HOLD, 16'h0000, 16'h0000, 16'hA3A3);
    chk("modes_beats", beats, 6);
    chk("modes_err", err, 0);

    // Fault: flip bit 0 of lane 1 q (A3 -> A2).
    @(negedge clk);
    force dut.g_lane[1].u_lane.q = 8'hA2;
    @(posedge clk);
    #1;
    chk("fault_err", err, 1);
    @(negedge clk);
    release dut.g_lane[1].u_lane.q;
    repeat (3) @(posedge clk);
    #1;
    chk("fault_err_sticky", err, 1);

    // Clear with a concurrent beat that must be dropped.
    @(posedge clk);
    #1;
    clear = 1'b1; in_valid = 1'b1; mode = LOAD; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    chk("clear_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_err", err, 0);
    chk("clear_beats", beats, 0);
    chk("clear_out_valid", out_valid, 0);
    chk("clear_y", y, 0);
    send(HOLD, 16'h0000, 16'h0000, 16'h0000);
    chk("post_clear_beats", beats, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("post_clear_err", err, 0);

    // Saturating counter on the CNT_W=4 instance.
    @(posedge clk);
    #1 s_in_valid = 1'b1;
    repeat (14) @(posedge clk);
    #1 chk("sat_14", s_beats, 4'hE);
    repeat (1) @(posedge clk);
    #1 chk("sat_15", s_beats, 4'hF);
    repeat (5) @(posedge clk);
    #1 chk("sat_20", s_beats, 4'hF);
    s_in_valid = 1'b0;

    // Asynchronous reset while an output beat is pending.
    out_ready = 1'b0;
    send(XOR_AND, 16'h0102, 16'h0000, 16'h0102);
    chk("pend_out_valid", out_valid, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_y", y, 0);
    chk("arst_beats", beats, 0);
    chk("arst_err", err, 0);
    chk("arst_sat_beats", s_beats, 0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_replay", out_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
